// File: rtl/cordic_vector_if.sv
// Sample/result bundle for cordic_vector.
//   in_valid, x_in, y_in       : I/Q sample in, qualified by in_valid
//   mag_out, phase_out         : magnitude and binary-angle phase out
//   out_valid                  : mag_out/phase_out belong to a valid sample
// master drives samples and receives results; slave is the CORDIC side.
interface cordic_vector_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] x_in;
  logic [DATA_WIDTH-1:0] y_in;
  logic [DATA_WIDTH-1:0] mag_out;
  logic [DATA_WIDTH-1:0] phase_out;
  logic                  out_valid;

  modport master (
    output in_valid, x_in, y_in,
    input  mag_out, phase_out, out_valid
  );

  modport slave (
    input  in_valid, x_in, y_in,
    output mag_out, phase_out, out_valid
  );
endinterface

// File: rtl/cordic_vector.sv
// Pipelined 8-bit vectoring-mode CORDIC: (x, y) -> (magnitude, atan2(y, x)).
// Phase is binary angle, 256 counts per turn (0x40 = pi/2).
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset, clears every register
//   ena    : global clock enable; all stages and the valid chain hold when low
//   bus    : cordic_vector_if slave (in_valid/x_in/y_in in, mag/phase/out_valid out)
// Latency is 8 enabled edges: pre-rotation, 6 iterations, output scaling.
module cordic_vector #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PIPELINE   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  cordic_vector_if.slave   bus
);

  // Two guard bits: +128 after negation and the ~1.65 CORDIC gain both fit.
  localparam int unsigned IntW    = DATA_WIDTH + 2;
  localparam int unsigned NumIter = 6;
  localparam int unsigned MulW    = 17;

  // atan(2^-i) in binary angle, rounded.
  function automatic logic [7:0] atan_lut(input int i);
    logic [7:0] a;
    case (i)
      0:       a = 8'h20;
      1:       a = 8'h13;
      2:       a = 8'h0A;
      3:       a = 8'h05;
      4:       a = 8'h03;
      5:       a = 8'h01;
      default: a = 8'h00;
    endcase
    return a;
  endfunction

  logic signed [IntW-1:0] x_q [NumIter+1];
  logic signed [IntW-1:0] x_d [NumIter+1];
  logic signed [IntW-1:0] y_q [NumIter+1];
  logic signed [IntW-1:0] y_d [NumIter+1];
  logic        [7:0]      z_q [NumIter+1];
  logic        [7:0]      z_d [NumIter+1];

  logic [PIPELINE-1:0]    vld_q, vld_d;
  logic [7:0]             mag_q, mag_d;
  logic [7:0]             phase_q, phase_d;

  logic signed [IntW-1:0] x_in_s, y_in_s;
  logic signed [MulW-1:0] x_ext, prod, scaled;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    z_d = z_q;

    x_in_s = IntW'(signed'(bus.x_in));
    y_in_s = IntW'(signed'(bus.y_in));

    // Pre-rotation folds the left half-plane into the right by +/-90 degrees.
    if (!x_in_s[IntW-1]) begin
      x_d[0] = x_in_s;
      y_d[0] = y_in_s;
      z_d[0] = 8'h00;
    end else if (!y_in_s[IntW-1]) begin
      x_d[0] = y_in_s;
      y_d[0] = -x_in_s;
      z_d[0] = 8'h40;
    end else begin
      x_d[0] = -y_in_s;
      y_d[0] = x_in_s;
      z_d[0] = 8'hC0;
    end

    // Drive y toward zero; z accumulates the angle rotated away.
    for (int i = 0; i < int'(NumIter); i++) begin
      if (!y_q[i][IntW-1]) begin
        x_d[i+1] = x_q[i] + (y_q[i] >>> i);
        y_d[i+1] = y_q[i] - (x_q[i] >>> i);
        z_d[i+1] = z_q[i] + atan_lut(i);
      end else begin
        x_d[i+1] = x_q[i] - (y_q[i] >>> i);
        y_d[i+1] = y_q[i] + (x_q[i] >>> i);
        z_d[i+1] = z_q[i] - atan_lut(i);
      end
    end

    // Gain compensation: x * 77 / 128 ~= x / 1.6464, shift-add only.
    x_ext  = MulW'(x_q[NumIter]);
    prod   = (x_ext <<< 6) + (x_ext <<< 3) + (x_ext <<< 2) + x_ext;
    scaled = prod >>> 7;
    if (scaled < 0) begin
      mag_d = 8'h00;
    end else if (scaled > 255) begin
      mag_d = 8'hFF;
    end else begin
      mag_d = scaled[7:0];
    end
    phase_d = z_q[NumIter];

    vld_d = {vld_q[PIPELINE-2:0], bus.in_valid};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= int'(NumIter); i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
        z_q[i] <= '0;
      end
      vld_q   <= '0;
      mag_q   <= '0;
      phase_q <= '0;
    end else if (ena) begin
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      vld_q   <= vld_d;
      mag_q   <= mag_d;
      phase_q <= phase_d;
    end
  end

  assign bus.mag_out   = mag_q;
  assign bus.phase_out = phase_q;
  assign bus.out_valid = vld_q[PIPELINE-1];

endmodule

// File: tb/tb_cordic_vector.sv
module tb_cordic_vector;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic ena   = 1'b0;

  cordic_vector_if #(.DATA_WIDTH(8)) bus ();

  cordic_vector #(.DATA_WIDTH(8), .PIPELINE(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v;
    int   x;
    int   y;
    int   tag;
  } samp_t;

  typedef struct {
    int x;
    int y;
    int mag;
    int mag_tol;
    int ph;       // -1: phase not checked
  } vec_t;

  samp_t hist[$];    // one entry per enabled edge since reset
  vec_t  tbl[8];
  int    atan_tab[6];
  int    errors = 0;
  int    checks = 0;

  task automatic chk(input string name, input int act, input int exp, input int tol,
                     input bit modular);
    int d;
    checks++;
    d = act - exp;
    if (modular) begin
      d = d & 255;
      if (d > 127) d -= 256;
    end
    if (d < 0) d = -d;
    if (d > tol) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (+/- %0d)", name, act, exp, tol);
    end
  endtask

  // Vectoring CORDIC from its defining rules on plain integers.
  function automatic void ref_model(input int xi, input int yi, output int mag, output int ph);
    int x, y, z, xn;
    if (xi >= 0) begin
      x = xi;  y = yi;  z = 0;
    end else if (yi >= 0) begin
      x = yi;  y = -xi; z = 64;
    end else begin
      x = -yi; y = xi;  z = 192;
    end
    for (int i = 0; i < 6; i++) begin
      if (y >= 0) begin
        xn = x + (y >>> i);
        y  = y - (x >>> i);
        z  = z + atan_tab[i];
      end else begin
        xn = x - (y >>> i);
        y  = y + (x >>> i);
        z  = z - atan_tab[i];
      end
      x = xn;
    end
    mag = (x * 77) >>> 7;
    if (mag < 0) mag = 0;
    if (mag > 255) mag = 255;
    ph = z & 255;
  endfunction

  task automatic check_out();
    samp_t e;
    int    m, p;
    if (hist.size() >= 8) begin
      e = hist[hist.size() - 8];
      chk("out_valid", int'(bus.out_valid), int'(e.v), 0, 1'b0);
      if (e.v) begin
        ref_model(e.x, e.y, m, p);
        chk("mag_model", int'(bus.mag_out), m, 0, 1'b0);
        chk("phase_model", int'(bus.phase_out), p, 0, 1'b0);
        if (e.tag >= 0) begin
          chk("mag_table", int'(bus.mag_out), tbl[e.tag].mag, tbl[e.tag].mag_tol, 1'b0);
          if (tbl[e.tag].ph >= 0)
            chk("phase_table", int'(bus.phase_out), tbl[e.tag].ph, 2, 1'b1);
        end
      end
    end else begin
      chk("out_valid_fill", int'(bus.out_valid), 0, 0, 1'b0);
    end
  endtask

  task automatic step(input logic en, input logic v, input int x, input int y, input int tag);
    samp_t s;
    ena          = en;
    bus.in_valid = v;
    bus.x_in     = x[7:0];
    bus.y_in     = y[7:0];
    @(posedge clk);
    #1;
    if (en) begin
      s.v = v; s.x = x; s.y = y; s.tag = tag;
      hist.push_back(s);
    end
    check_out();
  endtask

  task automatic flush(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0, 0, -1);
  endtask

  task automatic check_zero(input string name);
    chk({name, "_valid"}, int'(bus.out_valid), 0, 0, 1'b0);
    chk({name, "_mag"},   int'(bus.mag_out),   0, 0, 1'b0);
    chk({name, "_phase"}, int'(bus.phase_out), 0, 0, 1'b0);
  endtask

  initial begin
    real p;
    p = 1.0;
    for (int i = 0; i < 6; i++) begin
      atan_tab[i] = $rtoi($atan(p) * 128.0 / 3.14159265358979 + 0.5);
      p = p / 2.0;
    end

    tbl[0] = '{x:  100, y:    0, mag: 100, mag_tol: 2, ph: 8'h00};
    tbl[1] = '{x:    0, y:  100, mag: 100, mag_tol: 2, ph: 8'h40};
    tbl[2] = '{x: -100, y:    0, mag: 100, mag_tol: 2, ph: 8'h80};
    tbl[3] = '{x:    0, y: -100, mag: 100, mag_tol: 2, ph: 8'hC0};
    tbl[4] = '{x:   70, y:   70, mag:  99, mag_tol: 2, ph: 8'h20};
    tbl[5] = '{x: -128, y: -128, mag: 181, mag_tol: 2, ph: 8'hA0};
    tbl[6] = '{x:  127, y: -127, mag: 180, mag_tol: 2, ph: 8'hE0};
    tbl[7] = '{x:    0, y:    0, mag:   0, mag_tol: 0, ph: -1};

    bus.in_valid = 1'b0;
    bus.x_in     = '0;
    bus.y_in     = '0;

    // Power-on reset.
    #2 rst_n = 1'b0;
    #3 check_zero("reset");
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Table vectors back to back.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, tbl[i].x, tbl[i].y, i);
    flush(9);

    // Valid gaps with distinct data.
    for (int i = 0; i < 12; i++) step(1'b1, logic'(i % 2 == 0), i * 11 - 60, 45 - i * 8, -1);
    flush(9);

    // Enable stall mid-stream, then again while results are emerging.
    step(1'b1, 1'b1,  90,  -20, -1);
    step(1'b1, 1'b1, -45,   77, -1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 13, 13, -1);
    step(1'b1, 1'b1, -90, -33, -1);
    step(1'b1, 1'b1,  12, 120, -1);
    flush(6);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 0, -1);
    flush(4);

    // Randomized stream with random enable and valid.
    for (int i = 0; i < 400; i++)
      step(logic'($urandom_range(0, 7) != 0), logic'($urandom_range(0, 1)),
           int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128, -1);

    // Reset with samples in flight, not aligned to the clock.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 60 - i * 30, 25 + i * 20, -1);
    #3 rst_n = 1'b0;
    #1 check_zero("async_reset");
    hist.delete();
    bus.in_valid = 1'b1;
    bus.x_in     = 8'd50;
    @(posedge clk);
    #1 check_zero("reset_held");
    @(negedge clk);
    #2 rst_n = 1'b1;
    flush(10);
    step(1'b1, 1'b1, -70, 35, -1);
    flush(9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
